// File: rtl/ctrl_unit.sv
// Instruction-sequencing control unit: fetch/decode/execute FSM driving the ALU, register file, DRAM and PC.
// Optional build macro SINGLE_STEP_EN adds a step input that gates every new fetch on a rising edge of step.
module ctrl_unit #(
    parameter int IW   = 8,
    parameter int RSEL = 4
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [IW-1:0]   instr_in,
    input  logic            z_flag,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            iram_rd,
    output logic            pc_inc,
    output logic            pc_load,
    output logic [3:0]      ALU_OP,
    output logic [RSEL-1:0] a_sel,
    output logic [RSEL-1:0] b_sel,
    output logic            b_imm,
    output logic            wr_en,
    output logic [RSEL-1:0] wr_sel,
    output logic            wr_src,
    output logic            dram_rd,
    output logic            dram_wr,
    output logic [IW-1:0]   imm_out,
    output logic            done
);

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {FETCH, FETCH_W, DECODE, IMM_W, EXEC, MEM_W, HALT, STEP_WAIT} state_t;
    localparam state_t RESUME = STEP_WAIT;
    logic step_q;
`else
    typedef enum logic [2:0] {FETCH, FETCH_W, DECODE, IMM_W, EXEC, MEM_W, HALT} state_t;
    localparam state_t RESUME = FETCH;
`endif

    state_t          state;
    logic [IW-1:0]   ir;
    logic [3:0]      op;
    logic [3:0]      in_op;
    logic [RSEL-1:0] n;

    assign op    = ir[IW-1 -: 4];
    assign in_op = instr_in[IW-1 -: 4];
    assign n     = ir[RSEL-1:0];

    function automatic logic two_byte(input logic [3:0] o);
        return (o == 4'h2) || (o == 4'h3) || (o == 4'h6) || (o == 4'h7) ||
               (o == 4'hD) || (o == 4'hE);
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] o);
        logic [3:0] c;
        c = 4'h0;
        if (o >= 4'h1 && o <= 4'h9) c = o;
        else if (o == 4'hA)         c = 4'h9;
        return c;
    endfunction

    // Jump decision uses z_flag as seen during EXEC itself
    assign pc_load = (state == EXEC) &&
                     (((op == 4'hD) && z_flag) || ((op == 4'hE) && !z_flag));

    // EXEC-cycle bus/strobe pattern, registered on the edge entering EXEC
    logic [RSEL-1:0] ex_a, ex_b, ex_wsel;
    logic            ex_bimm, ex_wr, ex_drd, ex_dwr;

    always_comb begin
        ex_a = '0; ex_b = '0; ex_wsel = '0;
        ex_bimm = 1'b0; ex_wr = 1'b0; ex_drd = 1'b0; ex_dwr = 1'b0;
        case (op)
            4'h1:                   begin ex_a = n; ex_wsel = n; ex_wr = 1'b1; end
            4'h2, 4'h3, 4'h6, 4'h7: begin ex_bimm = 1'b1; ex_wr = 1'b1; end
            4'h4, 4'h5, 4'h8:       begin ex_b = n; ex_wr = 1'b1; end
            4'h9:                   begin ex_a = n; ex_wr = 1'b1; end
            4'hA:                   begin ex_wsel = n; ex_wr = 1'b1; end
            4'hB:                   begin ex_a = n; ex_drd = 1'b1; end
            4'hC:                   begin ex_a = n; ex_dwr = 1'b1; end
            default: ;
        endcase
    end

    // Outputs are registered for the state being entered, so each strobe is high during its own state
    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= FETCH;
            ir      <= '0;
            imm_out <= '0;
            ALU_OP  <= 4'h0;
            iram_rd <= 1'b0;
            pc_inc  <= 1'b0;
            wr_en   <= 1'b0;
            dram_rd <= 1'b0;
            dram_wr <= 1'b0;
            a_sel   <= '0;
            b_sel   <= '0;
            b_imm   <= 1'b0;
            wr_sel  <= '0;
            wr_src  <= 1'b0;
            done    <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            iram_rd <= 1'b0;
            pc_inc  <= 1'b0;
            wr_en   <= 1'b0;
            dram_rd <= 1'b0;
            dram_wr <= 1'b0;
            a_sel   <= '0;
            b_sel   <= '0;
            b_imm   <= 1'b0;
            wr_sel  <= '0;
            wr_src  <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_q  <= step;
`endif
            case (state)
                // The FETCH left by reset is quiet; the read strobe issues on the first edge after RST drops
                FETCH: begin
                    if (!iram_rd) iram_rd <= 1'b1;
                    else begin
                        state  <= FETCH_W;
                        pc_inc <= 1'b1;
                    end
                end
                // ALU_OP is loaded here so it is already valid throughout DECODE
                FETCH_W: begin
                    ir      <= instr_in;
                    ALU_OP  <= alu_code(in_op);
                    iram_rd <= two_byte(in_op);
                    state   <= DECODE;
                end
                DECODE: begin
                    if (two_byte(op)) begin
                        state  <= IMM_W;
                        pc_inc <= 1'b1;
                    end else begin
                        state   <= EXEC;
                        a_sel   <= ex_a;
                        b_sel   <= ex_b;
                        b_imm   <= ex_bimm;
                        wr_en   <= ex_wr;
                        wr_sel  <= ex_wsel;
                        dram_rd <= ex_drd;
                        dram_wr <= ex_dwr;
                    end
                end
                IMM_W: begin
                    imm_out <= instr_in;
                    state   <= EXEC;
                    a_sel   <= ex_a;
                    b_sel   <= ex_b;
                    b_imm   <= ex_bimm;
                    wr_en   <= ex_wr;
                    wr_sel  <= ex_wsel;
                    dram_rd <= ex_drd;
                    dram_wr <= ex_dwr;
                end
                EXEC: begin
                    ALU_OP <= 4'h0;
                    if (op == 4'hB) begin
                        state  <= MEM_W;
                        wr_en  <= 1'b1;
                        wr_src <= 1'b1;
                    end else if (op == 4'hF) begin
                        state <= HALT;
                        done  <= 1'b1;
                    end else begin
                        state   <= RESUME;
                        iram_rd <= (RESUME == FETCH);
                    end
                end
                MEM_W: begin
                    state   <= RESUME;
                    iram_rd <= (RESUME == FETCH);
                end
`ifdef SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (step && !step_q) begin
                        state   <= FETCH;
                        iram_rd <= 1'b1;
                    end
                end
`endif
                default: state <= HALT;
            endcase
        end
    end

endmodule
